fifo_word_unpacker: RTL and testbench



---
 rtl/fifo_word_unpacker_if.sv | 26 ++
 rtl/fifo_word_unpacker.sv | 96 +++++++++
 tb/tb_fifo_word_unpacker.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_word_unpacker_if.sv
// Handshake bundle for fifo_word_unpacker: FIFO read side plus byte-stream output.
// master = unpacker, slave = FIFO/sink environment.
interface fifo_word_unpacker_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
);
    logic                  enable;
    logic                  fifo_empty;
    logic                  fifo_read;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [BYTE_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  busy;

    modport master (
        input  enable, fifo_empty, fifo_data, out_ready,
        output fifo_read, out_valid, out_data, out_last, busy
    );

    modport slave (
        output enable, fifo_empty, fifo_data, out_ready,
        input  fifo_read, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/fifo_word_unpacker.sv
// Pops DATA_WIDTH words from a FIFO and streams them out BYTE_WIDTH at a time.
// Define FIFO_UNPACKER_STATS_EN to add word_count/byte_count outputs.
module fifo_word_unpacker #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int MSB_FIRST  = 1
) (
    input  logic clk,
    input  logic reset,
    fifo_word_unpacker_if.master bus
`ifdef FIFO_UNPACKER_STATS_EN
    ,
    output logic [15:0] word_count,
    output logic [15:0] byte_count
`endif
);
    localparam int BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int IDX_W = $clog2(BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, REQ, CAPTURE, SEND} state_t;

    state_t                         state, state_nxt;
    logic [IDX_W-1:0]               idx;
    logic [IDX_W-1:0]               sel;
    logic [BYTES-1:0][BYTE_WIDTH-1:0] word_q;
    logic                           start;
    logic                           xfer;
    logic                           last;

    // Only sampled in IDLE and at the last-byte transfer; we are the FIFO's only reader.
    assign start = bus.enable && !bus.fifo_empty;
    assign xfer  = (state == SEND) && bus.out_ready;
    assign last  = (idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.fifo_read = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = (state != IDLE);
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ: begin
                bus.fifo_read = 1'b1;
                state_nxt     = CAPTURE;
            end
            CAPTURE: state_nxt = SEND;
            SEND: begin
                bus.out_valid = 1'b1;
                if (xfer && last) state_nxt = start ? REQ : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx    <= '0;
            word_q <= '0;
        end else if (state == CAPTURE) begin
            idx    <= '0;
            word_q <= bus.fifo_data;
        end else if (xfer) begin
            idx    <= last ? '0 : idx + IDX_W'(1);
        end
    end

    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign sel = LAST_IDX - idx;
        end else begin : g_lsb
            assign sel = idx;
        end
    endgenerate

    // Held word and index only change on capture/transfer, so data is stable under backpressure.
    assign bus.out_data = word_q[sel];
    assign bus.out_last = (state == SEND) && last;

`ifdef FIFO_UNPACKER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_count <= '0;
            byte_count <= '0;
        end else begin
            if (state == CAPTURE) word_count <= word_count + 16'd1;
            if (xfer)             byte_count <= byte_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Randomized/directed bench for fifo_word_unpacker: two DUTs (MSB and LSB order) in lockstep
// against a word-queue scoreboard and a simple array FIFO.
module tb_fifo_word_unpacker;
    localparam int DW = 32;
    localparam int BW = 8;
    localparam int NB = DW / BW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_word_unpacker_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus ();
    fifo_word_unpacker_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus_l ();

    assign bus_l.enable     = bus.enable;
    assign bus_l.fifo_empty = bus.fifo_empty;
    assign bus_l.fifo_data  = bus.fifo_data;
    assign bus_l.out_ready  = bus.out_ready;

`ifdef FIFO_UNPACKER_STATS_EN
    logic [15:0] word_count, byte_count, word_count_l, byte_count_l;
`endif

    fifo_word_unpacker #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .MSB_FIRST(1)) u_dut (
        .clk(clk), .reset(reset), .bus(bus)
`ifdef FIFO_UNPACKER_STATS_EN
        , .word_count(word_count), .byte_count(byte_count)
`endif
    );

    fifo_word_unpacker #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .MSB_FIRST(0)) u_dut_l (
        .clk(clk), .reset(reset), .bus(bus_l)
`ifdef FIFO_UNPACKER_STATS_EN
        , .word_count(word_count_l), .byte_count(byte_count_l)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // FIFO model: array with read/write pointers; registered read data
    logic [31:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pops = 0;
    int err_read = 0;
    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus.fifo_read) begin
            if (wr_ptr == rd_ptr) err_read <= err_read + 1;
            else begin
                bus.fifo_data <= mem[rd_ptr % 256];
                rd_ptr <= rd_ptr + 1;
            end
            pops <= pops + 1;
        end
    end

    // Scoreboard: queue of words expected to be streamed, in FIFO order
    logic [31:0] exp_w [$];
    int pos = 0;
    int rmode = 0;      // 0: always ready, 1: random ready
    int hold_left = 0;  // stall cycles to apply while byte index 1 is presented
    bit prev_stall = 0;
    logic [7:0] prev_data;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
        logic [31:0] s;
        s = w >> (8 * k);
        return s[7:0];
    endfunction

    task automatic push(input logic [31:0] w);
        mem[wr_ptr % 256] = w;
        wr_ptr++;
        exp_w.push_back(w);
    endtask

    always @(negedge clk) begin
        bit r;
        if (reset) begin
            // a word caught mid-stream by reset is discarded, never re-read
            if (pos != 0) begin
                void'(exp_w.pop_front());
                pos = 0;
            end
            prev_stall = 0;
            bus.out_ready = 1'b1;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("stall_data", {24'd0, bus.out_data}, {24'd0, prev_data});
            end
            if (bus.out_valid) begin
                if (exp_w.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
                else begin
                    chk("msb_byte", {24'd0, bus.out_data}, {24'd0, byte_of(exp_w[0], NB - 1 - pos)});
                    chk("lsb_byte", {24'd0, bus_l.out_data}, {24'd0, byte_of(exp_w[0], pos)});
                    chk("last", {31'd0, bus.out_last}, {31'd0, pos == NB - 1});
                end
            end
            r = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (hold_left > 0 && bus.out_valid && pos == 1) begin
                r = 1'b0;
                hold_left--;
            end
            bus.out_ready = r;
            prev_stall = bus.out_valid && !r;
            prev_data  = bus.out_data;
            if (bus.out_valid && r && exp_w.size() != 0) begin
                pos++;
                if (pos == NB) begin
                    void'(exp_w.pop_front());
                    pos = 0;
                end
            end
        end
    end

    task automatic wait_drain(input string tag, input int maxc);
        int c;
        c = 0;
        while ((exp_w.size() != 0 || bus.busy) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        if (c >= maxc) chk(tag, 32'd0, 32'd1);
    endtask

    initial begin
        int first_rd, first_vld, nrd, nvld, p0;
        int rd_c [$];
        int tx_c [$];
        int c;
        reset = 1'b1;
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_fifo_read", {31'd0, bus.fifo_read}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
        chk("rst_out_last", {31'd0, bus.out_last}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
`ifdef FIFO_UNPACKER_STATS_EN
        chk("rst_word_count", {16'd0, word_count}, 32'd0);
        chk("rst_byte_count", {16'd0, byte_count}, 32'd0);
`endif
        reset = 1'b0;
        bus.enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);

        // single word: latency and single pop
        push(32'hA1B2C3D4);
        first_rd = -1; first_vld = -1; nrd = 0; nvld = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.fifo_read) begin nrd++; if (first_rd < 0) first_rd = k; end
            if (bus.out_valid) begin nvld++; if (first_vld < 0) first_vld = k; end
        end
        chk("single_reads", nrd, 1);
        chk("single_first_read", first_rd, 1);
        chk("single_first_valid", first_vld, 3);
        chk("single_valid_cycles", nvld, NB);
        chk("single_busy_end", {31'd0, bus.busy}, 32'd0);

        // backpressure: 5 stall cycles while the second byte is presented
        hold_left = 5;
        push(32'hA1B2C3D4);
        nvld = 0; c = 0;
        @(negedge clk);
        while ((bus.busy || exp_w.size() != 0) && c < 40) begin
            if (bus.out_valid) nvld++;
            @(negedge clk);
            c++;
        end
        chk("bp_valid_cycles", nvld, NB + 5);
        chk("bp_hold_used", hold_left, 0);

        // back-to-back words: second pop right after the last-byte transfer
        push(32'h01020304);
        push(32'h05060708);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.fifo_read) rd_c.push_back(k);
            if (bus.out_valid) tx_c.push_back(k);
        end
        chk("b2b_reads", rd_c.size(), 2);
        chk("b2b_bytes", tx_c.size(), 8);
        if (rd_c.size() == 2 && tx_c.size() == 8) begin
            chk("b2b_no_bubble", rd_c[1], tx_c[3] + 1);
            chk("b2b_span", tx_c[7] - rd_c[0] + 1, 12);
        end
        chk("b2b_idle", {31'd0, bus.busy}, 32'd0);
        chk("b2b_err_read", err_read, 0);

        // enable drops after the first byte: word completes, no further pop
        p0 = pops;
        push(32'h0BADBEEF);
        push(32'h12345678);
        c = 0;
        while (!bus.out_valid && c < 20) begin @(negedge clk); c++; end
        if (c >= 20) chk("en_wait_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.enable = 1'b0;
        repeat (12) @(negedge clk);
        chk("en_pops", pops - p0, 1);
        chk("en_busy", {31'd0, bus.busy}, 32'd0);
        chk("en_fifo_level", wr_ptr - rd_ptr, 1);
        bus.enable = 1'b1;
        wait_drain("en_drain_timeout", 40);
        chk("en_fifo_empty", wr_ptr - rd_ptr, 0);

        // reset while the second byte is stalled
        hold_left = 20;
        push(32'hCAFEF00D);
        c = 0;
        while (!(bus.out_valid && bus.out_data == 8'hFE) && c < 20) begin @(negedge clk); c++; end
        if (c >= 20) chk("rst_wait_timeout", 32'd0, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_fifo_read", {31'd0, bus.fifo_read}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_out_data", {24'd0, bus.out_data}, 32'd0);
        chk("mid_rst_out_last", {31'd0, bus.out_last}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
`ifdef FIFO_UNPACKER_STATS_EN
        chk("mid_rst_word_count", {16'd0, word_count}, 32'd0);
        chk("mid_rst_byte_count", {16'd0, byte_count}, 32'd0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hold_left = 0;
        p0 = pops;
        push(32'h5A6B7C8D);
        wait_drain("post_rst_drain_timeout", 40);
        chk("post_rst_pops", pops - p0, 1);

        // stats: 3 words after a fresh reset
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        push(32'h11223344);
        push(32'h55667788);
        push(32'h99AABBCC);
        wait_drain("stats_drain_timeout", 60);
`ifdef FIFO_UNPACKER_STATS_EN
        chk("stats_word_count", {16'd0, word_count}, 32'd3);
        chk("stats_byte_count", {16'd0, byte_count}, 32'd12);
        chk("stats_lsb_word_count", {16'd0, word_count_l}, 32'd3);
`endif

        // random traffic: random pushes, ready and enable
        rmode = 1;
        c = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (c < 40 && $urandom_range(0, 3) == 0) begin
                push($urandom);
                c++;
            end
            bus.enable = ($urandom_range(0, 9) < 7);
        end
        bus.enable = 1'b1;
        wait_drain("rand_drain_timeout", 600);
        chk("rand_fifo_empty", wr_ptr - rd_ptr, 0);
        repeat (4) @(negedge clk);
        chk("rand_idle", {31'd0, bus.busy}, 32'd0);
        chk("err_read", err_read, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
